alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 167 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter in front of a shared 16-bit ALU
//
// Purpose:
//   Two requesters share one ALU. An IDLE -> EXEC -> RESP FSM serves one
//   request at a time. The grant is combinational in IDLE. Operands are
//   latched into registers that drive the ALU. The result and zero flag are
//   captured after one full ALU cycle and then held until the owner takes them.
//
// Configuration:
//   ALU_ARB_RR_EN defined   -> round-robin on a tie (pointer resets to req 0)
//   ALU_ARB_RR_EN undefined -> fixed priority, req0 always beats req1
//
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   reqN/opN/aN/bN                  request and operands from requester N
//   gntN                            request accepted this cycle (combinational)
//   rsp_validN / rsp_readyN         result handshake towards requester N
//   rsp_result / rsp_zero           captured ALU result and zero flag
//   alu_op / alu_a / alu_b          registered operands to the ALU
//   alu_result / alu_zero           ALU outputs
//   busy                            FSM is not in IDLE
module alu_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [3:0]       op0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  output logic             gnt0,
  output logic             rsp_valid0,
  input  logic             rsp_ready0,
  input  logic             req1,
  input  logic [3:0]       op1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt1,
  output logic             rsp_valid1,
  input  logic             rsp_ready1,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic [3:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_owner;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             w_pick1;
  logic             w_grant;
  logic             w_rsp_done;

`ifdef ALU_ARB_RR_EN
  // Requester favoured on a tie; after a grant the other one is favoured.
  logic r_prio;

  always_comb begin
    w_pick1 = req1 && (!req0 || r_prio);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prio <= 1'b0;
    end else if (w_grant) begin
      r_prio <= ~w_pick1;
    end
  end
`else
  always_comb begin
    w_pick1 = req1 && !req0;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    rsp_valid0 = 1'b0;
    rsp_valid1 = 1'b0;
    w_grant    = 1'b0;
    w_rsp_done = 1'b0;
    busy       = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        // Grants are held off while reset is asserted.
        if (!rst && (req0 || req1)) begin
          w_grant = 1'b1;
          gnt0    = !w_pick1;
          gnt1    = w_pick1;
          w_next  = S_EXEC;
        end
      end
      S_EXEC: begin
        w_next = S_RESP;
      end
      S_RESP: begin
        rsp_valid0 = !r_owner;
        rsp_valid1 = r_owner;
        w_rsp_done = r_owner ? rsp_ready1 : rsp_ready0;
        if (w_rsp_done) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner  <= 1'b0;
      r_op     <= 4'b0000;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
    end else begin
      if (w_grant) begin
        r_owner <= w_pick1;
        r_op    <= w_pick1 ? op1 : op0;
        r_a     <= w_pick1 ? a1 : a0;
        r_b     <= w_pick1 ? b1 : b0;
      end else if (w_rsp_done) begin
        r_op <= 4'b0000;
        r_a  <= '0;
        r_b  <= '0;
      end
      // The ALU has had the whole EXEC cycle to settle on the operand registers.
      if (r_state == S_EXEC) begin
        r_result <= alu_result;
        r_zero   <= alu_zero;
      end
    end
  end

  assign alu_op     = r_op;
  assign alu_a      = r_a;
  assign alu_b      = r_b;
  assign rsp_result = r_result;
  assign rsp_zero   = r_zero;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard testbench for alu_arbiter with a behavioural 16-bit ALU
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, rsp_ready0, rsp_ready1;
  logic [3:0]  op0, op1;
  logic [15:0] a0, b0, a1, b1;
  logic        gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_zero, busy;
  logic [15:0] rsp_result, alu_a, alu_b;
  logic [3:0]  alu_op;
  logic [15:0] alu_result;
  logic        alu_zero;

  int total = 0;
  int bad   = 0;
  logic [17:0] sb_q[$];
  logic [17:0] mon_e;
  int          grant_order[4];
  int          ngr;
  logic        idle_seen;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .op0(op0), .a0(a0), .b0(b0), .gnt0(gnt0),
    .rsp_valid0(rsp_valid0), .rsp_ready0(rsp_ready0),
    .req1(req1), .op1(op1), .a1(a1), .b1(b1), .gnt1(gnt1),
    .rsp_valid1(rsp_valid1), .rsp_ready1(rsp_ready1),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .busy(busy)
  );

  // ALU: {ainvert, binvert, sel}; sel 00 AND, 01 OR, 10 ADD, 11 SLT.
  logic [15:0] m_aa, m_bb, m_sum;
  always_comb begin
    m_aa  = alu_op[3] ? ~alu_a : alu_a;
    m_bb  = alu_op[2] ? ~alu_b : alu_b;
    m_sum = m_aa + m_bb + {15'b0, alu_op[2]};
    case (alu_op[1:0])
      2'b00:   alu_result = m_aa & m_bb;
      2'b01:   alu_result = m_aa | m_bb;
      2'b10:   alu_result = m_sum;
      default: alu_result = {15'b0, m_sum[15]};
    endcase
    alu_zero = (alu_result == 16'h0000);
  end

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every response handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && (rsp_valid0 || rsp_valid1)) begin
        chk("one_valid_only", {35'b0, rsp_valid0 & rsp_valid1}, 36'd0);
        if ((rsp_valid0 && rsp_ready0) || (rsp_valid1 && rsp_ready1)) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_rsp", {17'b0, rsp_valid1, rsp_result, rsp_zero}, 36'd0);
          end else begin
            mon_e = sb_q.pop_front();
            chk("rsp_owner_result_zero", {18'b0, rsp_valid1, rsp_result, rsp_zero}, {18'b0, mon_e});
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_idle();
    idle_seen = 1'b0;
    for (int i = 0; i < 20 && !idle_seen; i++) begin
      @(negedge clk);
      if (!busy) idle_seen = 1'b1;
    end
    chk("idle_timeout", {35'b0, busy}, 36'd0);
  endtask

  task automatic run_one(input int n, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] res, input logic z);
    @(posedge clk); #1;
    if (n == 0) begin req0 = 1'b1; op0 = op; a0 = a; b0 = b; end
    else        begin req1 = 1'b1; op1 = op; a1 = a; b1 = b; end
    sb_q.push_back({n[0], res, z});
    @(negedge clk);
    chk("gnt_same_cycle", {34'b0, gnt1, gnt0}, (n == 0) ? 36'd1 : 36'd2);
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    chk("exec_busy", {35'b0, busy}, 36'd1);
    chk("exec_operands", {alu_op, alu_a, alu_b}, {op, a, b});
    chk("exec_no_valid", {34'b0, rsp_valid1, rsp_valid0}, 36'd0);
    @(negedge clk);
    chk("resp_valid_at_grant_plus_2", {34'b0, rsp_valid1, rsp_valid0}, (n == 0) ? 36'd1 : 36'd2);
    @(negedge clk);
    chk("back_idle", {35'b0, busy}, 36'd0);
    chk("operands_cleared", {alu_op, alu_a, alu_b}, 36'd0);
  endtask

  initial begin
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; rsp_ready0 = 1'b1; rsp_ready1 = 1'b1;
    op0 = '0; op1 = '0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_alu_side", {alu_op, alu_a, alu_b}, 36'd0);
    chk("reset_rsp", {15'b0, rsp_result, rsp_zero, rsp_valid0, rsp_valid1, busy, gnt0, gnt1}, 36'd0);
    rst = 1'b0;

    // Basic add on requester 0, subtract-to-zero on requester 1.
    run_one(0, 4'b0010, 16'h0005, 16'h0003, 16'h0008, 1'b0);
    run_one(1, 4'b0110, 16'h1234, 16'h1234, 16'h0000, 1'b1);

    // Both requesters held together with ready always high.
    @(posedge clk); #1;
    req0 = 1'b1; op0 = 4'b0010; a0 = 16'h0001; b0 = 16'h0001;
    req1 = 1'b1; op1 = 4'b0000; a1 = 16'hFF00; b1 = 16'h0F0F;
    ngr = 0;
    for (int i = 0; i < 40 && ngr < 4; i++) begin
      @(negedge clk);
      if (gnt0 || gnt1) begin
        chk("no_double_grant", {35'b0, gnt0 & gnt1}, 36'd0);
        grant_order[ngr] = gnt1 ? 1 : 0;
        if (gnt1) sb_q.push_back({1'b1, 16'h0F00, 1'b0});
        else      sb_q.push_back({1'b0, 16'h0002, 1'b0});
        ngr++;
      end
    end
    chk("contention_grants", ngr, 36'd4);
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    wait_idle();
`ifdef ALU_ARB_RR_EN
    chk("rr_order", {32'b0, grant_order[0][0], grant_order[1][0], grant_order[2][0], grant_order[3][0]}, 36'b0101);
`else
    chk("fixed_order", {32'b0, grant_order[0][0], grant_order[1][0], grant_order[2][0], grant_order[3][0]}, 36'b0000);
`endif

    // Owner stalls the response while the other requester waits.
    rsp_ready0 = 1'b0;
    @(posedge clk); #1;
    req0 = 1'b1; op0 = 4'b0111; a0 = 16'h0002; b0 = 16'h0005;
    sb_q.push_back({1'b0, 16'h0001, 1'b0});
    @(negedge clk);
    chk("stall_gnt0", {34'b0, gnt1, gnt0}, 36'd1);
    @(posedge clk); #1;
    req0 = 1'b0;
    req1 = 1'b1; op1 = 4'b1100; a1 = 16'h00FF; b1 = 16'h0F00;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_hold", {17'b0, rsp_valid0, gnt1, rsp_result, rsp_zero}, {17'b0, 1'b1, 1'b0, 16'h0001, 1'b0});
    end
    @(posedge clk); #1;
    rsp_ready0 = 1'b1;
    @(negedge clk);
    chk("no_gnt_during_handshake", {35'b0, gnt1}, 36'd0);
    @(negedge clk);
    chk("gnt1_after_release", {34'b0, gnt1, gnt0}, 36'd2);
    if (gnt1) sb_q.push_back({1'b1, 16'hF000, 1'b0});
    @(posedge clk); #1;
    req1 = 1'b0;
    wait_idle();

    // Reset in EXEC abandons the transaction.
    @(posedge clk); #1;
    req0 = 1'b1; op0 = 4'b0001; a0 = 16'h00F0; b0 = 16'h0F00;
    @(negedge clk);
    chk("rst_case_gnt0", {35'b0, gnt0}, 36'd1);
    @(posedge clk); #1;
    req0 = 1'b0;
    #2;
    chk("in_exec_before_rst", {35'b0, busy}, 36'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_alu", {alu_op, alu_a, alu_b}, 36'd0);
    chk("async_rst_rsp", {17'b0, rsp_result, rsp_zero, rsp_valid0, busy}, 36'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_rsp_after_rst", {34'b0, rsp_valid1, rsp_valid0}, 36'd0);
    end
    run_one(0, 4'b0001, 16'h00F0, 16'h0F00, 16'h0FF0, 1'b0);

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", sb_q.size(), 36'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
